serial_alu_sequencer: RTL



---
 rtl/serial_alu_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU controller: runs one WIDTH-bit AND/OR/ADD/SUB/SLT through an
// external 1-bit ALU slice, LSB first, and reports result, zero, carry and overflow.
module serial_alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    input  logic             slice_set
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             carry_r;
    logic [CNTW-1:0]  idx;
    logic [2:0]       op_r;
    logic             slt_r;
    logic             msb_cin, msb_cout;

    logic             accept, last_bit, slt_bit;
    logic [WIDTH-1:0] res_next, final_res;

    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == RUN) && (idx == CNTW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next state is defaulted before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_cin  = 1'b0;
        slice_less = 1'b0;
        slice_op   = 3'b000;
        if (state == RUN) begin
            slice_a   = a_sh[0];
            slice_b   = b_sh[0];
            slice_cin = carry_r;
            slice_op  = op_r;
        end
    end

    // The last slice bit is folded in combinationally so all flags land on
    // the same edge that raises done.
    always_comb begin
        res_next  = {slice_result, res_sh};
        slt_bit   = slice_set ^ carry_r ^ slice_cout;
        final_res = slt_r ? {{(WIDTH-1){1'b0}}, slt_bit} : res_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry_r  <= 1'b0;
            idx      <= '0;
            op_r     <= 3'b000;
            slt_r    <= 1'b0;
            msb_cin  <= 1'b0;
            msb_cout <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            idx  <= '0;
            if (op[1:0] == 2'b11) begin
                // SLT is a subtract whose sign is corrected afterwards
                op_r    <= 3'b110;
                slt_r   <= 1'b1;
                carry_r <= 1'b1;
            end else begin
                op_r    <= op;
                slt_r   <= 1'b0;
                carry_r <= op[2];
            end
        end else if (state == RUN) begin
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh  <= res_next[WIDTH-1:1];
            carry_r <= slice_cout;
            idx     <= idx + 1'b1;
            if (last_bit) begin
                msb_cin  <= carry_r;
                msb_cout <= slice_cout;
                result   <= final_res;
                zero     <= (final_res == '0);
            end
        end
    end

    assign cout     = msb_cout;
    assign overflow = msb_cin ^ msb_cout;

endmodule
